// File: rtl/sram_bus_arbiter_pkg.sv
// Shared types for the two-master SRAM-like bus arbiter: owner encodings, bus widths, FSM states.
package sram_bus_arbiter_pkg;

    localparam int unsigned AddrW = 32;
    localparam int unsigned DataW = 32;
    localparam int unsigned SizeW = 2;
    localparam int unsigned StrbW = 4;

    typedef enum logic [0:0] {
        OwnInst = 1'b0,
        OwnData = 1'b1
    } owner_e;

    typedef enum logic [0:0] {
        StIdle = 1'b0,
        StLock = 1'b1
    } arb_state_e;

endpackage

// File: rtl/sram_bus_arbiter_owner_fifo.sv
// One-bit owner FIFO: records which master issued each accepted, not-yet-answered transaction.
module sram_bus_arbiter_owner_fifo
    import sram_bus_arbiter_pkg::*;
#(
    parameter int unsigned Depth = 2
) (
    input  logic   clk,
    input  logic   rstn,
    input  logic   push_i,
    input  owner_e push_owner_i,
    input  logic   pop_i,
    output owner_e head_o,
    output logic   full_o,
    output logic   empty_o
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = PtrW + 1;

    owner_e            mem_q [Depth];
    logic [PtrW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              do_push, do_pop;

    assign full_o  = (cnt_q == CntW'(Depth));
    assign empty_o = (cnt_q == '0);
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign head_o  = mem_q[rptr_q];

    // Pointers wrap naturally because Depth is a power of two.
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (do_push) wptr_d = wptr_q + PtrW'(1);
        if (do_pop)  rptr_d = rptr_q + PtrW'(1);
        unique case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + CntW'(1);
            2'b01:   cnt_d = cnt_q - CntW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q] <= push_owner_i;
    end

endmodule

// File: rtl/sram_bus_arbiter.sv
// Shares one SRAM-like memory port between the instruction and data masters with zero added
// latency; in-order responses are steered back using the owner FIFO.
module sram_bus_arbiter
    import sram_bus_arbiter_pkg::*;
#(
    parameter int unsigned OtDepth = 2
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             inst_req_i,
    input  logic             inst_wr_i,
    input  logic [SizeW-1:0] inst_size_i,
    input  logic [StrbW-1:0] inst_wstrb_i,
    input  logic [AddrW-1:0] inst_addr_i,
    input  logic [DataW-1:0] inst_wdata_i,
    output logic             inst_addr_ok_o,
    output logic             inst_data_ok_o,
    output logic [DataW-1:0] inst_rdata_o,
    input  logic             data_req_i,
    input  logic             data_wr_i,
    input  logic [SizeW-1:0] data_size_i,
    input  logic [StrbW-1:0] data_wstrb_i,
    input  logic [AddrW-1:0] data_addr_i,
    input  logic [DataW-1:0] data_wdata_i,
    output logic             data_addr_ok_o,
    output logic             data_data_ok_o,
    output logic [DataW-1:0] data_rdata_o,
    output logic             mem_req_o,
    output logic             mem_wr_o,
    output logic [SizeW-1:0] mem_size_o,
    output logic [StrbW-1:0] mem_wstrb_o,
    output logic [AddrW-1:0] mem_addr_o,
    output logic [DataW-1:0] mem_wdata_o,
    input  logic             mem_addr_ok_i,
    input  logic             mem_data_ok_i,
    input  logic [DataW-1:0] mem_rdata_i,
    output logic             proto_err_o
);

    arb_state_e state_q, state_d;
    owner_e     grant_q, grant_d, last_grant_q, last_grant_d, sel, head;
    logic       proto_err_q, proto_err_d;
    logic       full, empty, hs, pop;

    // Data has priority unless it just won and inst is waiting; a stalled request stays locked.
    always_comb begin
        sel = OwnInst;
        if (state_q == StLock) begin
            sel = grant_q;
        end else if (data_req_i && !(last_grant_q == OwnData && inst_req_i)) begin
            sel = OwnData;
        end
    end

    always_comb begin
        mem_req_o   = ~full & ((sel == OwnData) ? data_req_i : inst_req_i);
        mem_wr_o    = (sel == OwnData) ? data_wr_i    : inst_wr_i;
        mem_size_o  = (sel == OwnData) ? data_size_i  : inst_size_i;
        mem_wstrb_o = (sel == OwnData) ? data_wstrb_i : inst_wstrb_i;
        mem_addr_o  = (sel == OwnData) ? data_addr_i  : inst_addr_i;
        mem_wdata_o = (sel == OwnData) ? data_wdata_i : inst_wdata_i;
    end

    assign hs             = mem_req_o & mem_addr_ok_i;
    assign inst_addr_ok_o = hs & (sel == OwnInst);
    assign data_addr_ok_o = hs & (sel == OwnData);

    assign pop            = mem_data_ok_i & ~empty;
    assign inst_data_ok_o = pop & (head == OwnInst);
    assign data_data_ok_o = pop & (head == OwnData);
    assign inst_rdata_o   = mem_rdata_i;
    assign data_rdata_o   = mem_rdata_i;
    assign proto_err_o    = proto_err_q;

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = hs ? sel : last_grant_q;
        proto_err_d  = proto_err_q | (mem_data_ok_i & empty);
        unique case (state_q)
            StIdle: begin
                if (mem_req_o && !mem_addr_ok_i) begin
                    state_d = StLock;
                    grant_d = sel;
                end
            end
            StLock: begin
                if (hs) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q      <= StIdle;
            grant_q      <= OwnInst;
            last_grant_q <= OwnInst;
            proto_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            proto_err_q  <= proto_err_d;
        end
    end

    sram_bus_arbiter_owner_fifo #(
        .Depth(OtDepth)
    ) u_owner_fifo (
        .clk         (clk),
        .rstn        (rstn),
        .push_i      (hs),
        .push_owner_i(sel),
        .pop_i       (mem_data_ok_i),
        .head_o      (head),
        .full_o      (full),
        .empty_o     (empty)
    );

endmodule
